// File: rtl/mem_bus_sched.sv
// Sequencer/arbiter sharing one mem_access port between instruction fetch and data requests.
// One transfer in flight; wait states on mem_rdy are bounded by a WAIT_MAX timeout.
module mem_bus_sched #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WAIT_MAX   = 15,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bus_err,
  output logic              mem_en,
  output logic              mem_pc_data,
  output logic              mem_w_rd,
  output logic [ADDR_W-1:0] mem_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, RESP} state_t;

  localparam int              SW         = $clog2(STARVE_LIM + 1);
  localparam logic [7:0]      WAIT_LIM   = 8'(WAIT_MAX);
  localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_LIM);

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              f_ack_d, d_ack_d, err_d;
  logic [DATA_W-1:0] f_rdata_d, d_rdata_d;
  logic              mem_en_d, pc_data_d, w_rd_d;
  logic [ADDR_W-1:0] pc_d, addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              grant_fetch, finish, timeout;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    starve_d   = starve_q;
    f_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    f_rdata_d  = f_rdata;
    d_rdata_d  = d_rdata;
    mem_en_d   = mem_en;
    pc_data_d  = mem_pc_data;
    w_rd_d     = mem_w_rd;
    pc_d       = mem_pc;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    finish     = 1'b0;
    timeout    = 1'b0;
    // Data wins unless fetch has been passed over STARVE_LIM times in a row.
    grant_fetch = f_req && (!d_req || (starve_q == STARVE_TOP));

    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          state_d    = XFER;
          wait_cnt_d = '0;
          mem_en_d   = 1'b1;
          if (grant_fetch) begin
            pc_data_d = 1'b1;
            w_rd_d    = 1'b0;
            pc_d      = f_addr;
            addr_d    = '0;
            wdata_d   = '0;
            starve_d  = '0;
          end else begin
            pc_data_d = 1'b0;
            w_rd_d    = d_we;
            pc_d      = '0;
            addr_d    = d_addr;
            wdata_d   = d_we ? d_wdata : '0;
            starve_d  = f_req ? starve_q + SW'(1) : '0;
          end
        end
      end
      XFER, WAIT: begin
        if (mem_rdy) begin
          finish = 1'b1;
        end else if (wait_cnt_q == WAIT_LIM) begin
          finish  = 1'b1;
          timeout = 1'b1;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (finish) begin
          state_d   = RESP;
          mem_en_d  = 1'b0;
          pc_data_d = 1'b0;
          w_rd_d    = 1'b0;
          pc_d      = '0;
          addr_d    = '0;
          wdata_d   = '0;
          err_d     = timeout;
          // The latched grant type still sits on mem_pc_data/mem_w_rd at this point.
          if (mem_pc_data) begin
            f_ack_d   = 1'b1;
            f_rdata_d = timeout ? '1 : mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_w_rd) d_rdata_d = timeout ? '1 : mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      starve_q    <= '0;
      f_ack       <= 1'b0;
      d_ack       <= 1'b0;
      bus_err     <= 1'b0;
      f_rdata     <= '0;
      d_rdata     <= '0;
      mem_en      <= 1'b0;
      mem_pc_data <= 1'b0;
      mem_w_rd    <= 1'b0;
      mem_pc      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      f_ack       <= f_ack_d;
      d_ack       <= d_ack_d;
      bus_err     <= err_d;
      f_rdata     <= f_rdata_d;
      d_rdata     <= d_rdata_d;
      mem_en      <= mem_en_d;
      mem_pc_data <= pc_data_d;
      mem_w_rd    <= w_rd_d;
      mem_pc      <= pc_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_sched.sv
// Self-checking bench for mem_bus_sched: vector table of single transfers plus
// arbitration, back-to-back and reset-abort sequences, all scored through an ack queue.
module tb_mem_bus_sched;

  logic        clk, rst;
  logic        f_req, f_ack, d_req, d_we, d_ack, bus_err;
  logic [15:0] f_addr, d_addr, mem_pc, mem_addr;
  logic [7:0]  f_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_pc_data, mem_w_rd, mem_rdy;

  mem_bus_sched dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err),
    .mem_en(mem_en), .mem_pc_data(mem_pc_data), .mem_w_rd(mem_w_rd),
    .mem_pc(mem_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       is_data;
    logic       we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] mrdata;
    int         waits;
    int         exp_lat;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic       is_fetch;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ack_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic push_exp(input logic is_fetch, input logic [7:0] rdata, input logic err);
    exp_t e;
    e.is_fetch = is_fetch;
    e.rdata    = rdata;
    e.err      = err;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every ack pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (f_ack || d_ack)) begin
      exp_t e;
      ack_total++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_ack");
      end else begin
        e = exp_q.pop_front();
        check("ack_kind", {f_ack, d_ack}, {e.is_fetch, !e.is_fetch});
        check("ack_rdata", e.is_fetch ? f_rdata : d_rdata, e.rdata);
        check("ack_bus_err", bus_err, e.err);
        check("ack_mem_en_low", mem_en, 1'b0);
      end
    end else if (!rst && bus_err) begin
      fail_now("bus_err_without_ack");
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {f_ack, d_ack, bus_err, mem_en, mem_pc_data, mem_w_rd}, 6'd0);
    check({name, "_rdata"}, {f_rdata, d_rdata}, 16'd0);
    check({name, "_bus"}, {mem_pc, mem_addr, mem_wdata}, 40'd0);
  endtask

  // Single transfer from an idle bus, acting as requester and memory at once.
  task automatic do_xfer(input vec_t v);
    int k;
    logic got;
    logic [1:0]  e_ctl;
    logic [15:0] e_pc, e_addr;
    logic [7:0]  e_wd;
    push_exp(!v.is_data, v.exp_rdata, v.exp_err);
    e_ctl  = v.is_data ? {1'b0, v.we} : 2'b10;
    e_pc   = v.is_data ? 16'h0000 : v.addr;
    e_addr = v.is_data ? v.addr : 16'h0000;
    e_wd   = (v.is_data && v.we) ? v.wdata : 8'h00;
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    mem_rdata = v.mrdata;
    mem_rdy   = 1'b0;
    k   = 0;
    got = 1'b0;
    for (int n = 1; n <= 300 && !got; n++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        got = 1'b1;
        check("latency", n, v.exp_lat);
      end else if (mem_en) begin
        check("grant_ctl", {mem_pc_data, mem_w_rd}, e_ctl);
        check("grant_pc", mem_pc, e_pc);
        check("grant_addr", mem_addr, e_addr);
        if (v.is_data) check("grant_wdata", mem_wdata, e_wd);
        mem_rdy = (k >= v.waits);
        // Disturb the request operands mid-transfer; the bus must not follow.
        if (k == 1) begin
          f_addr = ~f_addr; d_addr = ~d_addr; d_wdata = ~d_wdata; d_we = ~d_we;
        end
        k++;
      end
    end
    if (!got) fail_now("xfer_ack_wait");
    f_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
  endtask

  // Both requesters active; d_req drops once drop_d_at acks have been seen.
  task automatic arb_seq(input int n_acks, input int drop_d_at, input logic [7:0] rd);
    int acks, last;
    f_req = 1'b1; f_addr = 16'h0400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010; d_wdata = 8'h00;
    mem_rdy = 1'b1; mem_rdata = rd;
    acks = 0; last = 0;
    for (int n = 1; n <= 100 && acks < n_acks; n++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        acks++;
        if (acks > 1) check("arb_spacing", n - last, 3);
        last = n;
        if (acks >= drop_d_at) d_req = 1'b0;
        if (acks >= n_acks) f_req = 1'b0;
      end
    end
    if (acks < n_acks) fail_now("arb_ack_wait");
    f_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic b2b_fetch();
    int acks, last;
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 16'h0500 + 16'(i);
      push_exp(1'b1, a[7:0] ^ 8'h5A, 1'b0);
    end
    f_req = 1'b1; f_addr = 16'h0500; mem_rdy = 1'b1;
    acks = 0; last = 0;
    for (int n = 1; n <= 100 && acks < 4; n++) begin
      @(negedge clk);
      if (f_ack) begin
        acks++;
        if (acks > 1) check("b2b_spacing", n - last, 3);
        last   = n;
        f_addr = f_addr + 16'd1;
        if (acks == 4) f_req = 1'b0;
      end else if (mem_en) begin
        check("b2b_pc", mem_pc, f_addr);
        mem_rdata = mem_pc[7:0] ^ 8'h5A;
      end
    end
    if (acks < 4) fail_now("b2b_ack_wait");
    f_req = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_abort();
    int acks_before;
    logic seen;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0042; d_wdata = 8'h00;
    mem_rdy = 1'b0; mem_rdata = 8'hC3;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = mem_en;
    end
    if (!seen) fail_now("abort_grant_wait");
    repeat (3) @(negedge clk);
    acks_before = ack_total;
    check("abort_in_wait_en", mem_en, 1'b1);
    #1 rst = 1'b1;
    #1 check("abort_async_en", mem_en, 1'b0);
    check_all_zero("abort_reset");
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ack", ack_total, acks_before);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //           data we  addr      wdata  mrdata waits lat exp    err
    vecs[0] = '{1'b0, 1'b0, 16'h0200, 8'h00, 8'hA9, 0,  2,  8'hA9, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h01FF, 8'h42, 8'hE7, 3,  5,  8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'h5C, 1,  3,  8'h5C, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'h0001, 8'h77, 8'h13, 0,  2,  8'h5C, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0ABC, 8'h00, 8'h66, 99, 17, 8'hFF, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'h0300, 8'h00, 8'h3C, 15, 17, 8'h3C, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h0301, 8'h00, 8'h3D, 16, 17, 8'hFF, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h8000, 8'h00, 8'h01, 2,  4,  8'h01, 1'b0};

    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", mem_en, 1'b0);

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Four data grants starve fetch, then fetch is forced.
    for (int i = 0; i < 4; i++) push_exp(1'b0, 8'h11, 1'b0);
    push_exp(1'b1, 8'h11, 1'b0);
    arb_seq(5, 5, 8'h11);

    // Simultaneous requests: data first, fetch right after.
    push_exp(1'b0, 8'h22, 1'b0);
    push_exp(1'b1, 8'h22, 1'b0);
    arb_seq(2, 1, 8'h22);

    b2b_fetch();

    reset_abort();
    do_xfer('{1'b1, 1'b0, 16'h0042, 8'h00, 8'h99, 0, 2, 8'h99, 1'b0});

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
